// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered 8N1 UART transmitter with sticky overflow flag
module uart_tx_engine #(
  parameter int DEPTH        = 32,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     uart_fifo_write_en,
  input  logic [7:0]               uart_fifo_data,
  input  logic                     overflow_clr,
  output logic                     tx_line,
  output logic                     tx_ready,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           bit_end, pop, push;
  assign tx_ready = fifo_count < (AW+1)'(DEPTH);
  assign tx_busy  = state != IDLE;
  assign push     = uart_fifo_write_en && tx_ready;
  assign bit_end  = baud == BW'(CLKS_PER_BIT - 1);
  // Pop either from idle or at the end of a stop bit, so frames chain without a gap
  assign pop      = fifo_count != '0 && (state == IDLE || (state == STOP && bit_end));
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= uart_fifo_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      overflow   <= (uart_fifo_write_en && !tx_ready) || (overflow && !overflow_clr);
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      tx_line <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      baud <= (state == IDLE || bit_end) ? '0 : baud + 1'b1;
      case (state)
        IDLE: if (pop) begin
          state   <= START;
          shreg   <= mem[rd_ptr];
          tx_line <= 1'b0;
        end
        START: if (bit_end) begin
          state   <= DATA;
          bit_idx <= '0;
          tx_line <= shreg[0];
        end
        DATA: if (bit_end) begin
          state   <= bit_idx == 3'd7 ? STOP : DATA;
          bit_idx <= bit_idx + 3'd1;
          tx_line <= bit_idx == 3'd7 ? 1'b1 : shreg[bit_idx + 3'd1];
        end
        STOP: if (bit_end) begin
          state   <= pop ? START : IDLE;
          tx_line <= !pop;
          if (pop) shreg <= mem[rd_ptr];
        end
      endcase
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized and directed checks against a frame-timeline model
module tb_uart_tx_engine;
  localparam int DEPTH = 4, CPB = 4, FRAME = 10 * CPB;
  logic clk = 0, rst_n = 0, we = 0, clr = 0;
  logic [7:0] din = 0;
  logic tx_line, tx_ready, tx_busy, overflow;
  logic [2:0] fifo_count;
  logic [6:0] dv;
  int errors = 0, checks = 0;
  byte unsigned q[$];
  logic [7:0] cur = 0;
  int cyc = 0, start = -1000, free_at = 0;
  logic m_ovf = 0;
  always #5 clk = ~clk;
  uart_tx_engine #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .uart_fifo_write_en(we), .uart_fifo_data(din),
    .overflow_clr(clr), .tx_line(tx_line), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );
  assign dv = {tx_line, tx_busy, fifo_count, overflow, tx_ready};
  // Line level is a pure function of time since the frame started and the byte in flight
  function automatic logic m_line();
    int off;
    if (cyc >= free_at) return 1'b1;
    off = (cyc - start) / CPB;
    return off == 0 ? 1'b0 : off == 9 ? 1'b1 : cur[off-1];
  endfunction
  function automatic logic [6:0] m_vec();
    return {m_line(), logic'(cyc < free_at), 3'(q.size()), m_ovf, logic'(q.size() < DEPTH)};
  endfunction
  task automatic m_reset();
    q.delete();
    free_at = 0;
    m_ovf = 0;
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic c);
    int n;
    we = w; din = d; clr = c;
    @(posedge clk);
    cyc++;
    n = q.size();
    if (n != 0 && cyc >= free_at) begin
      cur = q.pop_front();
      start = cyc;
      free_at = cyc + FRAME;
    end
    if (w && n < DEPTH) q.push_back(d);
    m_ovf = (w && n == DEPTH) ? 1'b1 : (c ? 1'b0 : m_ovf);
    #1;
    we = 0; clr = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    #12;
    checks++;
    if (dv !== 7'b1_0_000_0_1) begin errors++; $display("FAIL reset_state got=%b exp=%b", dv, 7'b1_0_000_0_1); end
    @(negedge clk) rst_n = 1;
    m_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
  endtask
  task automatic test_single();
    int busy = 0;
    step(1, 8'hA5, 0);
    checks++;
    if (tx_line !== 1'b1 || fifo_count !== 3'd1) begin errors++; $display("FAIL single_push line=%b cnt=%0d exp line=1 cnt=1", tx_line, fifo_count); end
    step(0, 0, 0);
    busy += tx_busy;
    checks++;
    if (tx_line !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL single_start line=%b busy=%b exp 0 1", tx_line, tx_busy); end
    for (int i = 0; i < 45; i++) begin
      step(0, 0, 0);
      busy += tx_busy;
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL single_frame cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
    checks++;
    if (busy != 40) begin errors++; $display("FAIL single_busy_len got=%0d exp=40", busy); end
  endtask
  task automatic test_back_to_back();
    int busy = 0;
    logic [2:0] cnt [3];
    for (int i = 0; i < 3; i++) begin
      step(1, 8'(i + 1), 0);
      busy += tx_busy;
      cnt[i] = fifo_count;
    end
    checks++;
    if (cnt[0] !== 3'd1 || cnt[1] !== 3'd1 || cnt[2] !== 3'd2) begin errors++; $display("FAIL b2b_counts got=%0d,%0d,%0d exp=1,1,2", cnt[0], cnt[1], cnt[2]); end
    for (int i = 0; i < 130; i++) begin
      step(0, 0, 0);
      busy += tx_busy;
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL b2b_frame cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
    checks++;
    if (busy != 120) begin errors++; $display("FAIL b2b_busy_len got=%0d exp=120", busy); end
  endtask
  task automatic test_overflow();
    for (int i = 0; i < 6; i++) step(1, 8'(8'h10 + i), 0);
    checks++;
    if (tx_ready !== 1'b0 || overflow !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_full ready=%b ovf=%b cnt=%0d exp 0 1 4", tx_ready, overflow, fifo_count); end
    for (int i = 0; i < 210; i++) begin
      step(0, 0, 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL ovf_drain cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
  endtask
  task automatic test_overflow_clr();
    step(0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0);
    step(1, 8'hFF, 1);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_set_wins ovf=%b cnt=%0d exp 1 4", overflow, fifo_count); end
    for (int i = 0; i < 210; i++) begin
      step(0, 0, 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL ovfclr_drain cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
  endtask
  task automatic test_stop_collision();
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0);
    for (int i = 0; i < 60 && cyc + 1 != free_at; i++) step(0, 0, 0);
    step(1, 8'hEE, 0);
    checks++;
    if (fifo_count !== 3'd3 || overflow !== 1'b1 || tx_line !== 1'b0) begin errors++; $display("FAIL stop_collision cnt=%0d ovf=%b line=%b exp 3 1 0", fifo_count, overflow, tx_line); end
    for (int i = 0; i < 180; i++) begin
      step(0, 0, 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL collision_drain cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
  endtask
  task automatic test_reset_mid_frame();
    for (int i = 0; i < 3; i++) step(1, 8'(8'h70 + i), 0);
    repeat (16) step(0, 0, 0);
    #2 rst_n = 0;
    #1;
    checks++;
    if (dv !== 7'b1_0_000_0_1) begin errors++; $display("FAIL async_abort got=%b exp=%b", dv, 7'b1_0_000_0_1); end
    m_reset();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
    rst_n = 0;
    m_reset();
    @(negedge clk) rst_n = 1;
    step(1, 8'h5A, 0);
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL first_push_after_reset cnt=%0d exp=1", fifo_count); end
    for (int i = 0; i < 45; i++) begin
      step(0, 0, 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL post_reset_frame cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
      checks++;
      if (dv !== m_vec()) begin errors++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, dv, m_vec()); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_overflow_clr();
    test_stop_collision();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DEPTH, default 32: TX FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868: clk cycles per serial bit; at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port uart_fifo_write_en, input, 1 bit: one-cycle push strobe from the data-memory store path.
REQ-006 SHALL have port uart_fifo_data, input, 8 bits: byte to push.
REQ-007 SHALL have port overflow_clr, input, 1 bit: clears the overflow flag.
REQ-008 SHALL have port tx_line, output, 1 bit: serial TX line, idle high.
REQ-009 SHALL have port tx_ready, output, 1 bit: FIFO not full.
REQ-010 SHALL have port tx_busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port fifo_count, output, $clog2(DEPTH)+1 bits: bytes queued, excluding the byte being shifted.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag, set when a push is dropped.

Function
REQ-013 FIFO SHALL be a circular buffer with wrapping read/write pointers and a count register; tx_ready = (fifo_count < DEPTH), derived combinationally from the count register.
REQ-014 Push SHALL be accepted on an edge where uart_fifo_write_en=1 and fifo_count<DEPTH; data is written at the write pointer, and the pointer wraps from DEPTH-1 to 0.
REQ-015 Push with fifo_count==DEPTH SHALL be dropped (no state change, FIFO contents intact) and SHALL set overflow at that edge. This holds even if a pop occurs on the same edge.
REQ-016 overflow SHALL stay set until an edge with overflow_clr=1. If a set and a clear occur on the same edge, the set SHALL win.
REQ-017 Simultaneous accepted push and pop SHALL leave fifo_count unchanged and advance both pointers.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP; tx_busy = (state != IDLE).
REQ-019 IDLE: tx_line=1. If fifo_count!=0 at an edge, the head byte SHALL be loaded into the shift register, popped, and the FSM SHALL enter START with the baud counter at 0.
REQ-020 tx_line SHALL be a registered output; the start-bit low SHALL appear one cycle after the edge on which the push was accepted into an empty FIFO while IDLE.
REQ-021 START SHALL drive tx_line=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
REQ-022 DATA SHALL drive the shift-register bits LSB first, each for CLKS_PER_BIT cycles. After bit 7, the FSM SHALL go to STOP.
REQ-023 STOP SHALL drive tx_line=1 for CLKS_PER_BIT cycles. At its end, if fifo_count!=0, the FSM SHALL pop and go directly to START (no idle gap); otherwise it SHALL go to IDLE.
REQ-024 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles, in 8N1 format.
REQ-025 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every bit boundary; no fractional baud.
REQ-026 Pushes during a frame SHALL NOT disturb the shift register or the bit timing.

Reset
REQ-027 While rst_n=0, the block SHALL set: state=IDLE, tx_line=1, pointers=0, fifo_count=0, overflow=0, baud counter=0, bit index=0, and therefore tx_ready=1 and tx_busy=0.
REQ-028 rst_n falling mid-frame SHALL immediately abort the frame, with tx_line=1 asynchronously, and discard all queued bytes.
REQ-029 The first push after rst_n rises SHALL be accepted on the first rising edge at which rst_n=1.

Verification (CLKS_PER_BIT=4, DEPTH=4)
REQ-030 Push 0xA5 when idle -> tx_line low 1 cycle after the push edge. Then tx_line = 0 (4 cycles), 1,0,1,0,0,1,0,1 (4 cycles each), 1 (4 cycles), then IDLE; tx_busy high for exactly 40 cycles.
REQ-031 Push 0x01, 0x02, 0x03 on consecutive cycles -> three frames back-to-back with no gap, 120 cycles total; fifo_count sequence 1,1,2 then decrements at each frame start.
REQ-032 Push 6 bytes on consecutive cycles while idle -> 5 accepted (1 in shifter, 4 queued), tx_ready=0, 6th dropped, overflow=1. The transmitted bytes are the first 5 in order.
REQ-033 overflow=1, then pulse overflow_clr -> overflow=0 next edge. A dropped push plus overflow_clr on the same edge -> overflow stays 1.
REQ-034 At fifo_count=4 mid-frame, push on the same edge the STOP→START pop occurs -> push dropped, overflow=1, fifo_count=3.
REQ-035 Assert rst_n=0 during bit 3 of a frame with 2 bytes queued -> tx_line=1 and fifo_count=0 immediately. After release, no further frames are sent until a new push.
